// File: rtl/ex_mdu_pkg.sv
// ============================================================================
// Module      : ex_mdu_pkg
// Description : Shared state encoding and defaults for the EX-stage MDU sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ex_mdu_pkg;

    localparam int MDU_TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        MDU_IDLE    = 2'd0,
        MDU_MUL_RUN = 2'd1,
        MDU_DIV_RUN = 2'd2,
        MDU_DONE    = 2'd3
    } mdu_state_e;

endpackage

`default_nettype wire

// File: rtl/mdu_watchdog.sv
// ============================================================================
// Module      : mdu_watchdog
// Description : Clear/enable saturating cycle counter flagging a hung MDU unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_watchdog
    import ex_mdu_pkg::*;
#(
    parameter int TIMEOUT = MDU_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_EXP = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CNT_EXP);

endmodule

`default_nettype wire

// File: rtl/ex_mdu_sched.sv
// ============================================================================
// Module      : ex_mdu_sched
// Description : Start/stall/result sequencer for the iterative mul and div units.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mdu_sched
    import ex_mdu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = MDU_TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_is_mul_inst,
    input  logic            ex_is_div_inst,
    input  logic            ex_kill,
    output logic            mul_start,
    input  logic            mul_done,
    input  logic [XLEN-1:0] mul_res,
    output logic            div_start,
    input  logic            div_done,
    input  logic [XLEN-1:0] div_res,
    output logic            unit_flush,
    output logic            mdu_stall,
    output logic            mdu_res_valid,
    output logic [XLEN-1:0] mdu_res,
    output logic            mdu_timeout
);

    mdu_state_e      state_q;
    mdu_state_e      state_d;
    logic [XLEN-1:0] res_q;
    logic [XLEN-1:0] res_d;
    logic            timeout_q;
    logic            timeout_d;

    logic            w_run;
    logic            w_accept;
    logic            w_sel_done;
    logic [XLEN-1:0] w_sel_res;
    logic            w_expired;

    assign w_run    = (state_q == MDU_MUL_RUN) || (state_q == MDU_DIV_RUN);
    assign w_accept = (state_q == MDU_IDLE) && ex_valid && !ex_kill
                      && (ex_is_mul_inst || ex_is_div_inst);

    // Only the unit that was started is listened to.
    assign w_sel_done = (state_q == MDU_MUL_RUN) ? mul_done : div_done;
    assign w_sel_res  = (state_q == MDU_MUL_RUN) ? mul_res  : div_res;

    mdu_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (!w_run),
        .en_i      (w_run),
        .expired_o (w_expired)
    );

    always_comb begin
        state_d       = state_q;
        res_d         = res_q;
        timeout_d     = timeout_q;
        mul_start     = 1'b0;
        div_start     = 1'b0;
        unit_flush    = 1'b0;
        mdu_stall     = 1'b0;
        mdu_res_valid = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                if (w_accept) begin
                    mdu_stall = 1'b1;
                    if (ex_is_mul_inst) begin
                        mul_start = 1'b1;
                        state_d   = MDU_MUL_RUN;
                    end else begin
                        div_start = 1'b1;
                        state_d   = MDU_DIV_RUN;
                    end
                end
            end
            MDU_MUL_RUN, MDU_DIV_RUN: begin
                mdu_stall = 1'b1;
                if (ex_kill) begin
                    unit_flush = 1'b1;
                    state_d    = MDU_IDLE;
                end else if (w_sel_done) begin
                    res_d   = w_sel_res;
                    state_d = MDU_DONE;
                end else if (w_expired) begin
                    timeout_d = 1'b1;
                    res_d     = '0;
                    state_d   = MDU_DONE;
                end
            end
            MDU_DONE: begin
                // No accept here: the finished instruction is still sitting in EX.
                mdu_res_valid = !ex_kill;
                state_d       = MDU_IDLE;
            end
            default: begin
                state_d = MDU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MDU_IDLE;
            res_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            res_q     <= res_d;
            timeout_q <= timeout_d;
        end
    end

    assign mdu_res     = res_q;
    assign mdu_timeout = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_mdu_sched.sv
// ============================================================================
// Module      : tb_ex_mdu_sched
// Description : Scoreboard bench for ex_mdu_sched with randomized mul/div traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mdu_sched;

    localparam int XLEN = 32;
    localparam int TO   = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ex_valid, ex_is_mul_inst, ex_is_div_inst, ex_kill;
    logic            mul_start, mul_done, div_start, div_done;
    logic [XLEN-1:0] mul_res, div_res, mdu_res;
    logic            unit_flush, mdu_stall, mdu_res_valid, mdu_timeout;

    ex_mdu_sched #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_is_mul_inst (ex_is_mul_inst),
        .ex_is_div_inst (ex_is_div_inst),
        .ex_kill        (ex_kill),
        .mul_start      (mul_start),
        .mul_done       (mul_done),
        .mul_res        (mul_res),
        .div_start      (div_start),
        .div_done       (div_done),
        .div_res        (div_res),
        .unit_flush     (unit_flush),
        .mdu_stall      (mdu_stall),
        .mdu_res_valid  (mdu_res_valid),
        .mdu_res        (mdu_res),
        .mdu_timeout    (mdu_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } ev_t;

    ev_t start_q[$];
    ev_t flush_q[$];
    ev_t res_q[$];

    int checks   = 0;
    int failures = 0;
    bit exp_stall   = 1'b0;
    bit exp_timeout = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clk) begin
        ev_t e;
        if (mul_start || div_start) begin
            if (start_q.size() == 0) begin
                chk("unexpected_start", {62'd0, mul_start, div_start}, 64'd0);
            end else begin
                e = start_q.pop_front();
                chk("start_cycle", 64'(cyc), 64'(e.cyc));
                chk("start_kind", {62'd0, mul_start, div_start}, e.val[0] ? 64'd2 : 64'd1);
            end
        end
        if (unit_flush) begin
            if (flush_q.size() == 0) begin
                chk("unexpected_flush", 64'(unit_flush), 64'd0);
            end else begin
                e = flush_q.pop_front();
                chk("flush_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (mdu_res_valid) begin
            if (res_q.size() == 0) begin
                chk("unexpected_result", 64'(mdu_res_valid), 64'd0);
            end else begin
                e = res_q.pop_front();
                chk("result_cycle", 64'(cyc), 64'(e.cyc));
                chk("result_value", 64'(mdu_res), 64'(e.val));
            end
        end
        chk("stall", 64'(mdu_stall), 64'(exp_stall));
        chk("timeout_flag", 64'(mdu_timeout), 64'(exp_timeout));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_unit(input bit is_mul, input bit done, input logic [31:0] res);
        if (is_mul) begin
            mul_done = done;
            mul_res  = done ? res : $urandom;
            div_done = 1'($urandom % 2);
            div_res  = $urandom;
        end else begin
            div_done = done;
            div_res  = done ? res : $urandom;
            mul_done = 1'($urandom % 2);
            mul_res  = $urandom;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mul_start"}, 64'(mul_start), 64'd0);
        chk({tag, "_div_start"}, 64'(div_start), 64'd0);
        chk({tag, "_unit_flush"}, 64'(unit_flush), 64'd0);
        chk({tag, "_stall"}, 64'(mdu_stall), 64'd0);
        chk({tag, "_res_valid"}, 64'(mdu_res_valid), 64'd0);
        chk({tag, "_res"}, 64'(mdu_res), 64'd0);
        chk({tag, "_timeout"}, 64'(mdu_timeout), 64'd0);
    endtask

    // One instruction: unit done in cycle T+k, kill in cycle T+j (j=0: none),
    // optional kill during the result cycle. Outcome decided from the rules.
    task automatic run_op(input bit is_mul, input int k, input int j,
                          input bit kill_done, input logic [31:0] res);
        int T;
        int E;
        int outcome;
        if (j >= 1 && j <= k && j <= TO) begin
            outcome = 0; E = j;
        end else if (k <= TO) begin
            outcome = 1; E = k;
        end else begin
            outcome = 2; E = TO;
        end
        tick();
        T = cyc;
        start_q.push_back('{cyc: T, val: 32'(is_mul)});
        if (outcome == 0)
            flush_q.push_back('{cyc: T + E, val: 32'd0});
        else if (!kill_done)
            res_q.push_back('{cyc: T + E + 1, val: (outcome == 1) ? res : 32'd0});
        ex_valid = 1'b1; ex_is_mul_inst = is_mul; ex_is_div_inst = !is_mul; ex_kill = 1'b0;
        drive_unit(is_mul, 1'($urandom % 2), $urandom);
        exp_stall = 1'b1;
        for (int c = 1; c <= E; c++) begin
            tick();
            drive_unit(is_mul, c == k, res);
            ex_kill = (c == j);
        end
        tick();
        drive_unit(is_mul, 1'b0, 32'd0);
        exp_stall = 1'b0;
        if (outcome == 0) begin
            ex_valid = 1'b0; ex_kill = 1'b0;
        end else begin
            ex_kill = kill_done;
            if (outcome == 2) exp_timeout = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        bit v, m, d;
        for (int i = 0; i < n; i++) begin
            tick();
            v = 1'($urandom % 2); m = 1'($urandom % 2); d = 1'($urandom % 2);
            ex_valid = v; ex_is_mul_inst = m; ex_is_div_inst = d;
            ex_kill = (v && (m || d)) ? 1'b1 : 1'($urandom % 2);
            drive_unit(1'($urandom % 2), 1'($urandom % 2), $urandom);
            exp_stall = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ex_valid = 0; ex_is_mul_inst = 0; ex_is_div_inst = 0; ex_kill = 0;
        mul_done = 0; div_done = 0; mul_res = '0; div_res = '0;
        #12;
        check_all_zero("reset");
        tick();
        tick();
        rst_n = 1'b1;
        idle(2);

        run_op(1'b1, 4, 0, 1'b0, 32'h0000_0006);
        idle(1);
        run_op(1'b0, 7, 0, 1'b0, 32'hFFFF_FFFF);
        run_op(1'b0, 10, 3, 1'b0, 32'hDEAD_BEEF);
        run_op(1'b1, 2, 0, 1'b0, 32'h1111_2222);
        run_op(1'b1, 3, 3, 1'b0, 32'h3333_4444);
        tick();
        ex_valid = 1'b1; ex_is_mul_inst = 1'b1; ex_is_div_inst = 1'b0; ex_kill = 1'b1;
        exp_stall = 1'b0;
        run_op(1'b1, 1, 0, 1'b0, 32'hA5A5_5A5A);
        run_op(1'b1, TO + 5, 0, 1'b0, 32'h7777_7777);
        run_op(1'b0, 2, 0, 1'b0, 32'h0BAD_F00D);
        run_op(1'b1, 2, 0, 1'b1, 32'h1357_9BDF);

        for (int n = 0; n < 60; n++) begin
            run_op(1'($urandom % 2), int'($urandom_range(1, TO + 2)),
                   ($urandom % 2) ? int'($urandom_range(1, TO + 1)) : 0,
                   ($urandom % 7) == 0, $urandom);
            if ($urandom % 2) idle(int'($urandom_range(1, 2)));
        end

        // Asynchronous reset in the middle of a multiply.
        tick();
        start_q.push_back('{cyc: cyc, val: 32'd1});
        ex_valid = 1'b1; ex_is_mul_inst = 1'b1; ex_is_div_inst = 1'b0; ex_kill = 1'b0;
        drive_unit(1'b1, 1'b0, 32'd0);
        exp_stall = 1'b1;
        tick(); drive_unit(1'b1, 1'b0, 32'd0);
        tick(); drive_unit(1'b1, 1'b0, 32'd0);
        #2;
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_is_mul_inst = 1'b0;
        exp_stall = 1'b0; exp_timeout = 1'b0;
        #1;
        check_all_zero("async_reset");
        tick();
        tick();
        rst_n = 1'b1;
        run_op(1'b1, 3, 0, 1'b0, 32'h1234_5678);
        tick();
        ex_valid = 1'b0; ex_kill = 1'b0;
        idle(3);
        tick();
        ex_valid = 1'b0;
        tick();

        chk("start_q_drained", 64'(start_q.size()), 64'd0);
        chk("flush_q_drained", 64'(flush_q.size()), 64'd0);
        chk("res_q_drained", 64'(res_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
